// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: handshake and fetch-control bundle between the test bench,
// the instruction decoder, the fetch unit and the run sequencer.
//   Parameters: T (PC/target width), D (return-stack depth).
//   master modport: drives Start/ProgSel/ProgCtr/CallEn/RetEn/Halt/CallTarget and
//                   observes FetchHold/JumpAbs/Target/Done/StackErr/Depth/CycleCount.
//   slave modport : the sequencer side (directions reversed).
interface prog_sequencer_if #(
  parameter int unsigned T = 12,
  parameter int unsigned D = 4
);
  localparam int unsigned DW = $clog2(D) + 1;

  logic          Start;
  logic [1:0]    ProgSel;
  logic [T-1:0]  ProgCtr;
  logic          CallEn;
  logic          RetEn;
  logic          Halt;
  logic [T-1:0]  CallTarget;
  logic          FetchHold;
  logic          JumpAbs;
  logic [T-1:0]  Target;
  logic          Done;
  logic          StackErr;
  logic [DW-1:0] Depth;
  logic [15:0]   CycleCount;

  modport master (
    output Start, ProgSel, ProgCtr, CallEn, RetEn, Halt, CallTarget,
    input  FetchHold, JumpAbs, Target, Done, StackErr, Depth, CycleCount
  );

  modport slave (
    input  Start, ProgSel, ProgCtr, CallEn, RetEn, Halt, CallTarget,
    output FetchHold, JumpAbs, Target, Done, StackErr, Depth, CycleCount
  );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller for the instruction-fetch program counter.
//   Owns the Start/Done handshake, launches program 0..3 at its entry address,
//   and implements call/return through a D-entry hardware return-address stack.
//   Ports: Clk, Reset (synchronous, active-high), bus (prog_sequencer_if.slave).
//   Optional: define PROG_SEQUENCER_CYCLE_COUNT_EN to build the 16-bit saturating
//   run-length counter on CycleCount; otherwise CycleCount is tied to zero.
module prog_sequencer #(
  parameter int unsigned   T     = 12,
  parameter int unsigned   D     = 4,
  parameter logic [T-1:0]  BASE0 = 'h000,
  parameter logic [T-1:0]  BASE1 = 'h100,
  parameter logic [T-1:0]  BASE2 = 'h200,
  parameter logic [T-1:0]  BASE3 = 'h300
) (
  input  logic                  Clk,
  input  logic                  Reset,
  prog_sequencer_if.slave       bus
);

  localparam int unsigned DW = $clog2(D) + 1;
  localparam int unsigned AW = $clog2(D);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state;
  logic [T-1:0]  r_stack [D];
  logic [DW-1:0] r_depth;
  logic          r_stack_err;
  logic [1:0]    r_sel;

  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;
  logic [T-1:0]  w_base;
  logic          w_push;
  logic          w_pop;
  logic          w_err_ev;
  logic          w_jump;
  logic [T-1:0]  w_target;

  assign w_full    = (r_depth == DW'(D));
  assign w_empty   = (r_depth == DW'(0));
  assign w_wr_idx  = AW'(r_depth);
  assign w_top_idx = AW'(r_depth - DW'(1));

  // Entry address of the selected program
  always_comb begin
    w_base = BASE0;
    case (r_sel)
      2'd0: w_base = BASE0;
      2'd1: w_base = BASE1;
      2'd2: w_base = BASE2;
      2'd3: w_base = BASE3;
      default: w_base = BASE0;
    endcase
  end

  // Jump/stack decode; RUN outputs follow this cycle's decoder inputs (Mealy).
  // A Start abort in RUN takes precedence and suppresses any stack action.
  always_comb begin
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_err_ev = 1'b0;
    w_jump   = 1'b0;
    w_target = '0;
    case (r_state)
      S_LAUNCH: begin
        w_jump   = 1'b1;
        w_target = w_base;
      end
      S_RUN: begin
        if (!bus.Start && !bus.Halt) begin
          if (bus.CallEn) begin
            if (!w_full) begin
              w_push   = 1'b1;
              w_jump   = 1'b1;
              w_target = bus.CallTarget;
            end else begin
              w_err_ev = 1'b1;
            end
          end else if (bus.RetEn) begin
            if (!w_empty) begin
              w_pop    = 1'b1;
              w_jump   = 1'b1;
              w_target = r_stack[w_top_idx];
            end else begin
              w_err_ev = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Run-control state machine with stack occupancy and sticky error
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_depth     <= '0;
      r_stack_err <= 1'b0;
      r_sel       <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_sel   <= bus.ProgSel;
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.Start) r_sel <= bus.ProgSel;
          else           r_state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_depth     <= '0;
          r_stack_err <= 1'b0;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          if (bus.Start) begin
            r_sel   <= bus.ProgSel;
            r_state <= S_ARMED;
          end else if (bus.Halt) begin
            r_state <= S_DONE;
          end else if (w_err_ev) begin
            r_stack_err <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_push) begin
            r_depth <= r_depth + DW'(1);
          end else if (w_pop) begin
            r_depth <= r_depth - DW'(1);
          end
        end
        S_DONE: begin
          if (bus.Start) begin
            r_sel   <= bus.ProgSel;
            r_state <= S_ARMED;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Return-address storage; occupancy alone defines validity, so no reset needed
  always_ff @(posedge Clk) begin
    if (w_push && !Reset) r_stack[w_wr_idx] <= bus.ProgCtr + T'(1);
  end

`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
  logic [15:0] r_cycle_count;

  // Saturating count of RUN cycles, frozen outside RUN
  always_ff @(posedge Clk) begin
    if (Reset)                      r_cycle_count <= 16'h0000;
    else if (r_state == S_LAUNCH)   r_cycle_count <= 16'h0000;
    else if (r_state == S_RUN && r_cycle_count != 16'hFFFF)
                                    r_cycle_count <= r_cycle_count + 16'h0001;
  end

  assign bus.CycleCount = r_cycle_count;
`else
  assign bus.CycleCount = 16'h0000;
`endif

  assign bus.FetchHold = !((r_state == S_LAUNCH) || (r_state == S_RUN));
  assign bus.JumpAbs   = w_jump;
  assign bus.Target    = w_target;
  assign bus.Done      = (r_state == S_DONE);
  assign bus.StackErr  = r_stack_err;
  assign bus.Depth     = r_depth;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed plus randomized bench for prog_sequencer, checked
// against a queue-based behavioural model of the run/call/return rules.
module tb_prog_sequencer;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  prog_sequencer_if #(.T(12), .D(4)) bus ();

  prog_sequencer #(.T(12), .D(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Model: 0 idle, 1 armed, 2 launch, 3 run, 4 done
  int          m_state;
  bit          m_valid = 1'b0;
  logic [11:0] m_stack[$];
  logic        m_err;
  logic [1:0]  m_sel;
  logic [15:0] m_cnt;
  logic [11:0] base_tab [4] = '{12'h000, 12'h100, 12'h200, 12'h300};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic rst, input logic start, input logic [1:0] sel,
                     input logic [11:0] pc, input logic call, input logic ret,
                     input logic halt, input logic [11:0] ctgt);
    Reset          = rst;
    bus.Start      = start;
    bus.ProgSel    = sel;
    bus.ProgCtr    = pc;
    bus.CallEn     = call;
    bus.RetEn      = ret;
    bus.Halt       = halt;
    bus.CallTarget = ctgt;
  endtask

  // Compare every output to the model, clock once, advance the model.
  task automatic step();
    logic        ej;
    logic [11:0] et;
    logic [15:0] ec;
    ej = 1'b0;
    et = 12'h000;
    if (m_state == 2) begin
      ej = 1'b1;
      et = base_tab[m_sel];
    end else if (m_state == 3 && !bus.Start && !bus.Halt) begin
      if (bus.CallEn) begin
        if (m_stack.size() < 4) begin ej = 1'b1; et = bus.CallTarget; end
      end else if (bus.RetEn) begin
        if (m_stack.size() > 0) begin ej = 1'b1; et = m_stack[$]; end
      end
    end
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    ec = m_cnt;
`else
    ec = 16'h0000;
`endif
    #1;
    if (m_valid) begin
      chk("FetchHold",  16'(bus.FetchHold), 16'(!(m_state == 2 || m_state == 3)));
      chk("JumpAbs",    16'(bus.JumpAbs),   16'(ej));
      chk("Target",     16'(bus.Target),    16'(et));
      chk("Done",       16'(bus.Done),      16'(m_state == 4));
      chk("StackErr",   16'(bus.StackErr),  16'(m_err));
      chk("Depth",      16'(bus.Depth),     16'(m_stack.size()));
      chk("CycleCount", bus.CycleCount,     ec);
    end
    @(posedge Clk);
    if (Reset) begin
      m_valid = 1'b1;
      m_state = 0;
      m_stack.delete();
      m_err   = 1'b0;
      m_sel   = 2'd0;
      m_cnt   = 16'h0000;
    end else begin
      case (m_state)
        0: if (bus.Start) begin m_sel = bus.ProgSel; m_state = 1; end
        1: if (bus.Start) m_sel = bus.ProgSel; else m_state = 2;
        2: begin m_stack.delete(); m_err = 1'b0; m_cnt = 16'h0000; m_state = 3; end
        3: begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
          if (bus.Start) begin m_sel = bus.ProgSel; m_state = 1; end
          else if (bus.Halt) m_state = 4;
          else if (bus.CallEn) begin
            if (m_stack.size() < 4) m_stack.push_back(bus.ProgCtr + 12'h001);
            else begin m_err = 1'b1; m_state = 4; end
          end else if (bus.RetEn) begin
            if (m_stack.size() > 0) void'(m_stack.pop_back());
            else begin m_err = 1'b1; m_state = 4; end
          end
        end
        default: if (bus.Start) begin m_sel = bus.ProgSel; m_state = 1; end
      endcase
    end
    @(negedge Clk);
  endtask

  task automatic idle_in();
    drv(1'b0, 1'b0, m_sel, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  // From IDLE/DONE: Start one cycle, release, pass through LAUNCH into RUN.
  task automatic launch(input logic [1:0] sel);
    drv(1'b0, 1'b1, sel, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000); step();
    drv(1'b0, 1'b0, sel, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000); step();
    step();
  endtask

  task automatic call(input logic [11:0] pc, input logic [11:0] tgt);
    drv(1'b0, 1'b0, m_sel, pc, 1'b1, 1'b0, 1'b0, tgt); step();
  endtask

  initial begin
    @(negedge Clk);
    drv(1'b1, 1'b0, 2'd0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000);
    step();
    step();
    idle_in();
    step();

    // Launch program 2 with Start high for 3 cycles
    drv(1'b0, 1'b1, 2'd2, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000);
    step(); step(); step();
    drv(1'b0, 1'b0, 2'd2, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000);
    step();
    #1;
    chk("launch_jump",   16'(bus.JumpAbs),   16'h0001);
    chk("launch_target", 16'(bus.Target),    16'h0200);
    chk("launch_hold",   16'(bus.FetchHold), 16'h0000);
    step();

    // Call then return
    drv(1'b0, 1'b0, 2'd2, 12'h205, 1'b1, 1'b0, 1'b0, 12'h2A0);
    #1;
    chk("call_jump",   16'(bus.JumpAbs), 16'h0001);
    chk("call_target", 16'(bus.Target),  16'h02A0);
    step();
    chk("call_depth", 16'(bus.Depth), 16'h0001);
    drv(1'b0, 1'b0, 2'd2, 12'h2A0, 1'b0, 1'b0, 1'b0, 12'h000); step();
    drv(1'b0, 1'b0, 2'd2, 12'h2A1, 1'b0, 1'b1, 1'b0, 12'h000);
    #1;
    chk("ret_target", 16'(bus.Target), 16'h0206);
    step();
    chk("ret_depth", 16'(bus.Depth), 16'h0000);

    // Overflow on 5th nested call
    for (int i = 0; i < 4; i++) call(12'h210 + 12'(i), 12'h400 + 12'(i * 16));
    drv(1'b0, 1'b0, 2'd2, 12'h430, 1'b1, 1'b0, 1'b0, 12'h500);
    #1;
    chk("ovf_jump", 16'(bus.JumpAbs), 16'h0000);
    step();
    chk("ovf_err",  16'(bus.StackErr), 16'h0001);
    chk("ovf_done", 16'(bus.Done),     16'h0001);
    launch(2'd1);
    chk("relaunch_err",   16'(bus.StackErr), 16'h0000);
    chk("relaunch_depth", 16'(bus.Depth),    16'h0000);

    // Underflow, then Halt with simultaneous CallEn
    drv(1'b0, 1'b0, 2'd1, 12'h100, 1'b0, 1'b1, 1'b0, 12'h000); step();
    chk("unf_err",  16'(bus.StackErr), 16'h0001);
    chk("unf_done", 16'(bus.Done),     16'h0001);
    launch(2'd3);
    call(12'h300, 12'h380);
    drv(1'b0, 1'b0, 2'd3, 12'h380, 1'b1, 1'b0, 1'b1, 12'h3C0); step();
    chk("halt_call_done",  16'(bus.Done),  16'h0001);
    chk("halt_call_depth", 16'(bus.Depth), 16'h0001);

    // Halt after 10 RUN cycles
    launch(2'd0);
    for (int i = 0; i < 9; i++) begin
      drv(1'b0, 1'b0, 2'd0, 12'(i), 1'b0, 1'b0, 1'b0, 12'h000); step();
    end
    drv(1'b0, 1'b0, 2'd0, 12'h009, 1'b0, 1'b0, 1'b1, 12'h000); step();
    chk("halt_done", 16'(bus.Done),      16'h0001);
    chk("halt_hold", 16'(bus.FetchHold), 16'h0001);
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    chk("halt_count", bus.CycleCount, 16'd10);
`else
    chk("halt_count", bus.CycleCount, 16'd0);
`endif
    drv(1'b0, 1'b1, 2'd0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000); step();
    chk("restart_done", 16'(bus.Done), 16'h0000);
    drv(1'b0, 1'b0, 2'd0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000); step();
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic st;
      int unsigned r;
      r  = $urandom_range(99);
      st = 1'b0;
      case (m_state)
        0, 4: st = (r < 30);
        1:    st = (r < 50);
        3:    st = (r < 3);
        default: st = 1'b0;
      endcase
      drv(($urandom_range(199) == 0), st, 2'($urandom), 12'($urandom),
          ($urandom_range(99) < 30), ($urandom_range(99) < 25),
          ($urandom_range(99) < 3), 12'($urandom));
      step();
    end

    // Reset mid-run with three entries stacked
    idle_in(); step();
    if (m_state != 0 && m_state != 4) begin
      drv(1'b1, 1'b0, 2'd0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000); step();
    end
    launch(2'd1);
    for (int i = 0; i < 3; i++) call(12'h120 + 12'(i), 12'h180 + 12'(i * 8));
    chk("pre_reset_depth", 16'(bus.Depth), 16'h0003);
    drv(1'b1, 1'b0, 2'd1, 12'h190, 1'b0, 1'b0, 1'b0, 12'h000); step();
    chk("rst_depth", 16'(bus.Depth),     16'h0000);
    chk("rst_done",  16'(bus.Done),      16'h0000);
    chk("rst_hold",  16'(bus.FetchHold), 16'h0001);
    idle_in();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
